vga_mem_arbiter: RTL and testbench

Arbiter for the single-port video memory behind the VGA address translator. The VGA scan-out read path has absolute priority while a pixel is inside one of the three 150x150 image windows. Write requests from the vector processor are buffered in a small FIFO and retired into memory only in cycles when the display does not need the port. The block sits between the translator, the processor result path and the frame RAM (67500 words, addresses 0x00000–0x107AB).

---
 rtl/vga_mem_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_vga_mem_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vga_mem_arbiter
// Purpose  : Shares the single-port frame RAM (67500 words) between the VGA
//            scan-out read path and buffered vector-processor writes. Display
//            reads inside an image window always own the port; buffered writes
//            retire one per cycle whenever the display does not need it.
// Ports    :
//   clock25      in   25 MHz pixel clock, only clock
//   reset_n      in   synchronous active-low reset
//   vga_addr     in   read address from the address translator
//   vga_image_on in   current pixel lies in an image window
//   vga_data     out  pixel word for the colour stage (registered)
//   vga_valid    out  vga_data belongs to an image-window pixel
//   wr_req       in   processor write request
//   wr_addr      in   processor write address
//   wr_data      in   processor write data
//   wr_ready     out  write buffer can accept (transfer on wr_req && wr_ready)
//   mem_addr     out  RAM address
//   mem_wdata    out  RAM write data
//   mem_we       out  RAM write enable
//   mem_rdata    in   RAM read data, one-cycle synchronous latency
//   err_clr      in   clears wr_addr_err
//   wr_addr_err  out  sticky: an out-of-range write was dropped
//   starve       out  sticky: writes blocked by the display too long
//   fifo_level   out  current write-buffer occupancy
// Revision : 1.0 - initial release
// ============================================================================
module vga_mem_arbiter #(
    parameter int unsigned  DATA_W       = 8,
    parameter int unsigned  FIFO_DEPTH   = 4,
    parameter logic [16:0]  MEM_WORDS    = 17'h107AC,
    parameter logic [16:0]  ZERO_ADDR    = 17'h107AC,
    parameter int unsigned  STARVE_LIMIT = 1024
) (
    input  logic                              clock25,
    input  logic                              reset_n,
    input  logic [16:0]                       vga_addr,
    input  logic                              vga_image_on,
    output logic [DATA_W-1:0]                 vga_data,
    output logic                              vga_valid,
    input  logic                              wr_req,
    input  logic [16:0]                       wr_addr,
    input  logic [DATA_W-1:0]                 wr_data,
    output logic                              wr_ready,
    output logic [16:0]                       mem_addr,
    output logic [DATA_W-1:0]                 mem_wdata,
    output logic                              mem_we,
    input  logic [DATA_W-1:0]                 mem_rdata,
    input  logic                              err_clr,
    output logic                              wr_addr_err,
    output logic                              starve,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level
);

    localparam int unsigned          c_AW           = $clog2(FIFO_DEPTH);
    localparam logic [c_AW:0]        c_DEPTH        = FIFO_DEPTH[c_AW:0];
    localparam logic [15:0]          c_STARVE_LIMIT = STARVE_LIMIT[15:0];

    // Port grant encoding
    localparam logic [1:0] c_GRANT_IDLE    = 2'd0;
    localparam logic [1:0] c_GRANT_DISPLAY = 2'd1;
    localparam logic [1:0] c_GRANT_WRITE   = 2'd2;

    // ------------------------------------------------------------------------
    // Write buffer storage and state
    // ------------------------------------------------------------------------
    logic [16:0]        r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]  r_fifo_data [FIFO_DEPTH];
    logic [c_AW-1:0]    r_wptr;
    logic [c_AW-1:0]    r_rptr;
    logic [c_AW:0]      r_level;

    logic               r_err;
    logic               r_starve;
    logic [15:0]        r_starve_cnt;

    logic               r_on_d1;
    logic               r_on_d2;
    logic [DATA_W-1:0]  r_vga_data;

    logic               w_full;
    logic               w_empty;
    logic               w_handshake;
    logic               w_in_range;
    logic               w_push;
    logic               w_pop;
    logic               w_addr_err;
    logic [1:0]         w_grant;
    logic [15:0]        w_starve_cnt_next;

    assign w_full      = (r_level == c_DEPTH);
    assign w_empty     = (r_level == '0);
    assign wr_ready    = !w_full;
    assign w_handshake = wr_req && !w_full;
    assign w_in_range  = (wr_addr < MEM_WORDS);

    // Reset blocks every buffer update, so a reset during a drain discards
    // the queue and the write presented in that cycle never reaches RAM.
    assign w_push      = reset_n && w_handshake && w_in_range;
    assign w_addr_err  = w_handshake && !w_in_range;

    // ------------------------------------------------------------------------
    // Port grant: display read wins unconditionally, then buffered writes
    // ------------------------------------------------------------------------
    always_comb begin
        w_grant = c_GRANT_IDLE;
        if (vga_image_on) begin
            w_grant = c_GRANT_DISPLAY;
        end else if (!w_empty) begin
            w_grant = c_GRANT_WRITE;
        end
    end

    assign w_pop = reset_n && (w_grant == c_GRANT_WRITE);

    always_comb begin
        mem_addr  = ZERO_ADDR;
        mem_wdata = '0;
        mem_we    = 1'b0;
        case (w_grant)
            c_GRANT_DISPLAY: mem_addr = vga_addr;
            c_GRANT_WRITE: begin
                mem_addr  = r_fifo_addr[r_rptr];
                mem_wdata = r_fifo_data[r_rptr];
                mem_we    = reset_n;
            end
            default: mem_addr = ZERO_ADDR;
        endcase
    end

    // ------------------------------------------------------------------------
    // Write buffer
    // ------------------------------------------------------------------------
    always_ff @(posedge clock25) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= wr_addr;
            r_fifo_data[r_wptr] <= wr_data;
        end
    end

    always_ff @(posedge clock25) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign fifo_level = r_level;

    // ------------------------------------------------------------------------
    // Sticky address-error flag: a new error outranks a same-cycle clear
    // ------------------------------------------------------------------------
    always_ff @(posedge clock25) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (w_addr_err) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign wr_addr_err = r_err;

    // ------------------------------------------------------------------------
    // Starvation monitor: counts consecutive full-and-display cycles. The flag
    // is raised on the edge the count reaches the limit, so it is not lost if
    // the window closes right after.
    // ------------------------------------------------------------------------
    always_comb begin
        w_starve_cnt_next = '0;
        if (w_full && (w_grant == c_GRANT_DISPLAY)) begin
            if (r_starve_cnt == c_STARVE_LIMIT) begin
                w_starve_cnt_next = r_starve_cnt;
            end else begin
                w_starve_cnt_next = r_starve_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clock25) begin
        if (!reset_n) begin
            r_starve_cnt <= '0;
            r_starve     <= 1'b0;
        end else begin
            r_starve_cnt <= w_starve_cnt_next;
            if (w_starve_cnt_next == c_STARVE_LIMIT) begin
                r_starve <= 1'b1;
            end
        end
    end

    assign starve = r_starve;

    // ------------------------------------------------------------------------
    // Read path: first delay stage lines up with RAM read data, second with
    // the registered pixel word.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock25) begin
        if (!reset_n) begin
            r_on_d1    <= 1'b0;
            r_on_d2    <= 1'b0;
            r_vga_data <= '0;
        end else begin
            r_on_d1    <= vga_image_on;
            r_on_d2    <= r_on_d1;
            r_vga_data <= r_on_d1 ? mem_rdata : '0;
        end
    end

    assign vga_data  = r_vga_data;
    assign vga_valid = r_on_d2;

endmodule
`default_nettype wire

// File: tb/tb_vga_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_mem_arbiter
// Purpose  : Directed self-checking bench for vga_mem_arbiter. Inputs change
//            on the falling edge, outputs are examined 1 ns later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_mem_arbiter;

    logic        clock25 = 1'b0;
    logic        reset_n = 1'b0;
    logic [16:0] vga_addr = '0;
    logic        vga_image_on = 1'b0;
    logic [7:0]  vga_data;
    logic        vga_valid;
    logic        wr_req = 1'b0;
    logic [16:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_ready;
    logic [16:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata = '0;
    logic        err_clr = 1'b0;
    logic        wr_addr_err;
    logic        starve;
    logic [2:0]  fifo_level;

    integer errors = 0;
    integer checks = 0;

    vga_mem_arbiter #(
        .DATA_W       (8),
        .FIFO_DEPTH   (4),
        .MEM_WORDS    (17'h107AC),
        .ZERO_ADDR    (17'h107AC),
        .STARVE_LIMIT (8)
    ) dut (
        .clock25      (clock25),
        .reset_n      (reset_n),
        .vga_addr     (vga_addr),
        .vga_image_on (vga_image_on),
        .vga_data     (vga_data),
        .vga_valid    (vga_valid),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_rdata    (mem_rdata),
        .err_clr      (err_clr),
        .wr_addr_err  (wr_addr_err),
        .starve       (starve),
        .fifo_level   (fifo_level)
    );

    always #20 clock25 = ~clock25;

    // RAM model: one-cycle read latency; 0x057E4 holds 0x33, every other
    // word returns a non-zero pattern so output gating is visible.
    always @(posedge clock25) begin
        if (mem_addr == 17'h057E4) mem_rdata <= 8'h33;
        else                       mem_rdata <= mem_addr[7:0] | 8'h80;
    end

    task automatic do_reset();
        @(negedge clock25);
        reset_n = 1'b0; wr_req = 1'b0; vga_image_on = 1'b0; err_clr = 1'b0;
        @(negedge clock25);
        @(negedge clock25);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        @(negedge clock25);
        #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we_in_reset: got %0b want 0", mem_we); end
        @(negedge clock25);
        reset_n = 1'b1;
        #1;
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", wr_ready); end
        checks++; if (vga_data !== 8'h00 || vga_valid !== 1'b0) begin errors++; $display("FAIL reset_vga: got %0h/%0b want 0/0", vga_data, vga_valid); end
        checks++; if (wr_addr_err !== 1'b0 || starve !== 1'b0) begin errors++; $display("FAIL reset_flags: got err=%0b starve=%0b want 0/0", wr_addr_err, starve); end
        checks++; if (mem_we !== 1'b0 || mem_addr !== 17'h107AC) begin errors++; $display("FAIL reset_idle: got we=%0b addr=%0h want 0/107ac", mem_we, mem_addr); end
    endtask

    task automatic test_write();
        @(negedge clock25);
        wr_req = 1'b1; wr_addr = 17'h00010; wr_data = 8'h5A;
        #1;
        checks++; if (wr_ready !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL write_hs: got ready=%0b we=%0b want 1/0", wr_ready, mem_we); end
        @(negedge clock25);
        wr_req = 1'b0;
        #1;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 17'h00010 || mem_wdata !== 8'h5A) begin errors++; $display("FAIL write_mem: got we=%0b addr=%0h data=%0h want 1/10/5a", mem_we, mem_addr, mem_wdata); end
        checks++; if (fifo_level !== 3'd1 || wr_ready !== 1'b1) begin errors++; $display("FAIL write_level1: got lvl=%0d ready=%0b want 1/1", fifo_level, wr_ready); end
        @(negedge clock25);
        #1;
        checks++; if (fifo_level !== 3'd0 || mem_we !== 1'b0) begin errors++; $display("FAIL write_level0: got lvl=%0d we=%0b want 0/0", fifo_level, mem_we); end
    endtask

    task automatic test_read();
        @(negedge clock25);
        vga_image_on = 1'b1; vga_addr = 17'h057E4;
        #1;
        checks++; if (mem_addr !== 17'h057E4 || mem_we !== 1'b0) begin errors++; $display("FAIL read_addr: got addr=%0h we=%0b want 57e4/0", mem_addr, mem_we); end
        @(negedge clock25);
        vga_image_on = 1'b0; vga_addr = 17'h00001;
        #1;
        checks++; if (vga_valid !== 1'b0) begin errors++; $display("FAIL read_early_valid: got %0b want 0", vga_valid); end
        checks++; if (mem_addr !== 17'h107AC) begin errors++; $display("FAIL read_idle_addr: got %0h want 107ac", mem_addr); end
        @(negedge clock25);
        #1;
        checks++; if (vga_data !== 8'h33 || vga_valid !== 1'b1) begin errors++; $display("FAIL read_data: got %0h/%0b want 33/1", vga_data, vga_valid); end
        @(negedge clock25);
        #1;
        checks++; if (vga_data !== 8'h00 || vga_valid !== 1'b0) begin errors++; $display("FAIL read_off: got %0h/%0b want 0/0", vga_data, vga_valid); end
    endtask

    task automatic test_range();
        @(negedge clock25);
        wr_req = 1'b1; wr_addr = 17'h107AC; wr_data = 8'h11;
        #1;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL range_ready: got %0b want 1", wr_ready); end
        @(negedge clock25);
        wr_req = 1'b0;
        #1;
        checks++; if (wr_addr_err !== 1'b1) begin errors++; $display("FAIL range_err_set: got %0b want 1", wr_addr_err); end
        checks++; if (mem_we !== 1'b0 || fifo_level !== 3'd0) begin errors++; $display("FAIL range_dropped: got we=%0b lvl=%0d want 0/0", mem_we, fifo_level); end
        @(negedge clock25);
        wr_req = 1'b1; wr_addr = 17'h107AB; wr_data = 8'h22;
        @(negedge clock25);
        wr_req = 1'b0;
        #1;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 17'h107AB || mem_wdata !== 8'h22) begin errors++; $display("FAIL range_last_word: got we=%0b addr=%0h data=%0h want 1/107ab/22", mem_we, mem_addr, mem_wdata); end
        checks++; if (wr_addr_err !== 1'b1) begin errors++; $display("FAIL range_sticky: got %0b want 1", wr_addr_err); end
        @(negedge clock25);
        err_clr = 1'b1;
        @(negedge clock25);
        err_clr = 1'b0;
        #1;
        checks++; if (wr_addr_err !== 1'b0) begin errors++; $display("FAIL range_clr: got %0b want 0", wr_addr_err); end
        @(negedge clock25);
        err_clr = 1'b1; wr_req = 1'b1; wr_addr = 17'h1FFFF; wr_data = 8'h99;
        @(negedge clock25);
        err_clr = 1'b0; wr_req = 1'b0;
        #1;
        checks++; if (wr_addr_err !== 1'b1) begin errors++; $display("FAIL range_set_wins: got %0b want 1", wr_addr_err); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL range_level: got %0d want 0", fifo_level); end
    endtask

    task automatic test_display_priority();
        logic [16:0] exp_addr;
        logic [7:0]  exp_data;
        for (int i = 0; i < 150; i++) begin
            @(negedge clock25);
            vga_image_on = 1'b1;
            exp_addr = 17'h00100 + 17'(i);
            vga_addr = exp_addr;
            if (i < 4) begin
                wr_req = 1'b1; wr_addr = 17'h00200 + 17'(i); wr_data = 8'hA0 + 8'(i);
            end else if (i < 8) begin
                wr_req = 1'b1; wr_addr = 17'h003FF; wr_data = 8'hEE;
            end else begin
                wr_req = 1'b0;
            end
            #1;
            checks++; if (mem_we !== 1'b0 || mem_addr !== exp_addr) begin errors++; $display("FAIL disp_port[%0d]: got we=%0b addr=%0h want 0/%0h", i, mem_we, mem_addr, exp_addr); end
            if (i >= 4) begin
                checks++; if (wr_ready !== 1'b0 || fifo_level !== 3'd4) begin errors++; $display("FAIL disp_full[%0d]: got ready=%0b lvl=%0d want 0/4", i, wr_ready, fifo_level); end
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clock25);
            vga_image_on = 1'b0; wr_req = 1'b0;
            exp_addr = 17'h00200 + 17'(i);
            exp_data = 8'hA0 + 8'(i);
            #1;
            checks++; if (mem_we !== 1'b1 || mem_addr !== exp_addr || mem_wdata !== exp_data) begin errors++; $display("FAIL disp_drain[%0d]: got we=%0b addr=%0h data=%0h want 1/%0h/%0h", i, mem_we, mem_addr, mem_wdata, exp_addr, exp_data); end
        end
        @(negedge clock25);
        #1;
        checks++; if (mem_we !== 1'b0 || fifo_level !== 3'd0) begin errors++; $display("FAIL disp_done: got we=%0b lvl=%0d want 0/0", mem_we, fifo_level); end
    endtask

    task automatic run_starve(input int k, input logic exp);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock25);
            vga_image_on = 1'b1; vga_addr = 17'h00500;
            wr_req = 1'b1; wr_addr = 17'h00600 + 17'(i); wr_data = 8'(i);
        end
        for (int j = 0; j < k; j++) begin
            @(negedge clock25);
            wr_req = 1'b0; vga_image_on = 1'b1;
        end
        @(negedge clock25);
        vga_image_on = 1'b0;
        #1;
        checks++; if (starve !== exp) begin errors++; $display("FAIL starve_%0d: got %0b want %0b", k, starve, exp); end
        repeat (4) @(negedge clock25);
        #1;
        checks++; if (starve !== exp || fifo_level !== 3'd0) begin errors++; $display("FAIL starve_after_%0d: got starve=%0b lvl=%0d want %0b/0", k, starve, fifo_level, exp); end
    endtask

    task automatic test_starve();
        do_reset();
        run_starve(7, 1'b0);
        run_starve(8, 1'b1);
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock25);
            vga_image_on = 1'b1; vga_addr = 17'h00700;
            wr_req = 1'b1; wr_addr = 17'h00800 + 17'(i); wr_data = 8'h40 + 8'(i);
        end
        @(negedge clock25);
        vga_image_on = 1'b0; wr_req = 1'b0; reset_n = 1'b0;
        #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL mid_we_suppressed: got %0b want 0", mem_we); end
        checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL mid_level_before: got %0d want 3", fifo_level); end
        @(negedge clock25);
        reset_n = 1'b1;
        #1;
        checks++; if (fifo_level !== 3'd0 || mem_we !== 1'b0 || wr_ready !== 1'b1) begin errors++; $display("FAIL mid_after: got lvl=%0d we=%0b ready=%0b want 0/0/1", fifo_level, mem_we, wr_ready); end
        @(negedge clock25);
        #1;
        checks++; if (mem_we !== 1'b0 || mem_addr !== 17'h107AC) begin errors++; $display("FAIL mid_idle: got we=%0b addr=%0h want 0/107ac", mem_we, mem_addr); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_range();
        test_display_priority();
        test_starve();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
